random_noise_checker: RTL and testbench

RANDOM_NOISE_CHECKER -- requirements
Module: random_noise_checker

---
 rtl/random_noise_checker.sv | 160 ++++++++++++++++
 tb/tb_random_noise_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/random_noise_checker.sv
`default_nettype none
// ============================================================================
// Module      : random_noise_checker
// Description : Locks onto a received LFSR noise word stream, then freewheels
//               a local predictor and counts mismatching words.
// Revision    : 1.0 - initial release
// ============================================================================
module random_noise_checker #(
    parameter int N            = 8,
    parameter int LOCK_MATCHES = 4,
    parameter int LOSS_ERRORS  = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N-1:0]     in_word,
    input  logic             clear_counts,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    localparam logic [3:0] c_lock_matches = 4'(LOCK_MATCHES);
    localparam logic [3:0] c_loss_errors  = 4'(LOSS_ERRORS);

    state_t           r_state, w_state_nxt;
    logic [N-1:0]     r_pred, w_pred_nxt;
    logic [3:0]       r_match, w_match_nxt;
    logic [3:0]       r_bad, w_bad_nxt;
    logic             r_locked, r_error;
    logic [CNT_W-1:0] r_err_count, r_word_count;
    logic             w_err_nxt, w_inc_err, w_inc_wc;
    logic             w_fb_in, w_fb_pred;
    logic [N-1:0]     w_next_in, w_next_pred;

    // Feedback taps per supported width; unsupported widths shift in zeros.
    if (N == 4) begin : g_n4
        assign w_fb_in   = in_word[0] ^ in_word[1];
        assign w_fb_pred = r_pred[0]  ^ r_pred[1];
    end else if (N == 8) begin : g_n8
        assign w_fb_in   = in_word[0] ^ in_word[4] ^ in_word[5] ^ in_word[6];
        assign w_fb_pred = r_pred[0]  ^ r_pred[4]  ^ r_pred[5]  ^ r_pred[6];
    end else if (N == 32) begin : g_n32
        assign w_fb_in   = in_word[0] ^ in_word[25] ^ in_word[26] ^ in_word[30];
        assign w_fb_pred = r_pred[0]  ^ r_pred[25]  ^ r_pred[26]  ^ r_pred[30];
    end else begin : g_nx
        assign w_fb_in   = 1'b0;
        assign w_fb_pred = 1'b0;
    end

    assign w_next_in   = {w_fb_in,   in_word[N-1:1]};
    assign w_next_pred = {w_fb_pred, r_pred[N-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_match_nxt = r_match;
        w_bad_nxt   = r_bad;
        w_err_nxt   = 1'b0;
        w_inc_err   = 1'b0;
        w_inc_wc    = 1'b0;
        if (in_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (in_word != '0) begin
                        w_pred_nxt  = w_next_in;
                        w_match_nxt = 4'd0;
                        w_state_nxt = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (in_word == r_pred) begin
                        w_pred_nxt = w_next_in;
                        if (r_match + 4'd1 == c_lock_matches) begin
                            w_state_nxt = ST_LOCKED;
                            w_match_nxt = 4'd0;
                            w_bad_nxt   = 4'd0;
                        end else begin
                            w_match_nxt = r_match + 4'd1;
                        end
                    end else if (in_word == '0) begin
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_pred_nxt  = w_next_in;
                        w_match_nxt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    // Freewheel: once locked the data never reseeds the predictor.
                    w_pred_nxt = w_next_pred;
                    w_inc_wc   = 1'b1;
                    if (in_word == r_pred) begin
                        w_bad_nxt = 4'd0;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_inc_err = 1'b1;
                        w_bad_nxt = r_bad + 4'd1;
                        if (r_bad + 4'd1 == c_loss_errors) begin
                            w_state_nxt = ST_HUNT;
                        end
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_HUNT;
            r_pred   <= '0;
            r_match  <= 4'd0;
            r_bad    <= 4'd0;
            r_locked <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pred   <= w_pred_nxt;
            r_match  <= w_match_nxt;
            r_bad    <= w_bad_nxt;
            r_locked <= (w_state_nxt == ST_LOCKED);
            r_error  <= w_err_nxt;
        end
    end

    // Clear takes priority over a simultaneous increment; both saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count  <= '0;
            r_word_count <= '0;
        end else if (clear_counts) begin
            r_err_count  <= '0;
            r_word_count <= '0;
        end else begin
            if (w_inc_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (w_inc_wc && (r_word_count != '1)) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign locked     = r_locked;
    assign error      = r_error;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_random_noise_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_random_noise_checker
// Description : Directed vector bench for random_noise_checker (N=8, N=4,
//               and a narrow-counter N=8 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_random_noise_checker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // N=8, default counters
    logic        v8, c8;
    logic [7:0]  w8;
    logic        lk8, er8;
    logic [15:0] ec8, wc8;
    logic [1:0]  st8;

    // N=4
    logic        v4, c4;
    logic [3:0]  w4;
    logic        lk4, er4;
    logic [15:0] ec4, wc4;
    logic [1:0]  st4;

    // N=8, 4-bit counters
    logic        vs, cs;
    logic [7:0]  ws;
    logic        lks, ers;
    logic [3:0]  ecs, wcs;
    logic [1:0]  sts;

    random_noise_checker #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_word(w8), .clear_counts(c8),
        .locked(lk8), .error(er8), .err_count(ec8), .word_count(wc8), .state(st8));

    random_noise_checker #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_word(w4), .clear_counts(c4),
        .locked(lk4), .error(er4), .err_count(ec4), .word_count(wc4), .state(st4));

    random_noise_checker #(.N(8), .CNT_W(4)) duts (
        .clk(clk), .reset(reset), .in_valid(vs), .in_word(ws), .clear_counts(cs),
        .locked(lks), .error(ers), .err_count(ecs), .word_count(wcs), .state(sts));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step8(input logic v, input logic [7:0] w, input logic c);
        v8 = v; w8 = w; c8 = c;
        @(posedge clk);
        #1;
        v8 = 1'b0; c8 = 1'b0;
    endtask

    task automatic steps(input logic [7:0] w, input logic c);
        vs = 1'b1; ws = w; cs = c;
        @(posedge clk);
        #1;
        vs = 1'b0; cs = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  w;
        logic        clr;
        logic [1:0]  st;
        logic        lk;
        logic        er;
        logic [15:0] ec;
        logic [15:0] wc;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    logic [7:0] lock_seq [5];
    logic [3:0] seq4 [5];
    logic [1:0] exp4 [5];

    initial begin
        vecs[0]  = '{1'b1, 8'hFF, 1'b0, 2'b01, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[1]  = '{1'b1, 8'h7F, 1'b0, 2'b01, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[2]  = '{1'b1, 8'h3F, 1'b0, 2'b01, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[3]  = '{1'b1, 8'h9F, 1'b0, 2'b01, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[4]  = '{1'b1, 8'h4F, 1'b0, 2'b10, 1'b1, 1'b0, 16'd0, 16'd0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 2'b10, 1'b1, 1'b0, 16'd0, 16'd0};
        vecs[6]  = '{1'b1, 8'h00, 1'b0, 2'b10, 1'b1, 1'b1, 16'd1, 16'd1};
        vecs[7]  = '{1'b1, 8'h13, 1'b0, 2'b10, 1'b1, 1'b0, 16'd1, 16'd2};
        vecs[8]  = '{1'b1, 8'h09, 1'b0, 2'b10, 1'b1, 1'b0, 16'd1, 16'd3};
        vecs[9]  = '{1'b1, 8'h55, 1'b1, 2'b10, 1'b1, 1'b1, 16'd0, 16'd0};
        vecs[10] = '{1'b1, 8'h55, 1'b0, 2'b10, 1'b1, 1'b1, 16'd1, 16'd1};
        vecs[11] = '{1'b1, 8'h55, 1'b0, 2'b00, 1'b0, 1'b1, 16'd2, 16'd2};
        vecs[12] = '{1'b1, 8'hFF, 1'b0, 2'b01, 1'b0, 1'b0, 16'd2, 16'd2};
        vecs[13] = '{1'b1, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 16'd2, 16'd2};

        lock_seq = '{8'hFF, 8'h7F, 8'h3F, 8'h9F, 8'h4F};
        seq4     = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h8};
        exp4     = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        v8 = 0; w8 = 0; c8 = 0;
        v4 = 0; w4 = 0; c4 = 0;
        vs = 0; ws = 0; cs = 0;
        reset = 1'b1;
        #2;
        chk("reset state", {30'd0, st8}, 32'd0);
        chk("reset locked", {31'd0, lk8}, 32'd0);
        chk("reset error", {31'd0, er8}, 32'd0);
        chk("reset err_count", {16'd0, ec8}, 32'd0);
        chk("reset word_count", {16'd0, wc8}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Table: lock, error with recovery, clear, loss of lock, VERIFY zero
        for (int i = 0; i < NV; i++) begin
            step8(vecs[i].v, vecs[i].w, vecs[i].clr);
            chk($sformatf("vec%0d state", i), {30'd0, st8}, {30'd0, vecs[i].st});
            chk($sformatf("vec%0d locked", i), {31'd0, lk8}, {31'd0, vecs[i].lk});
            chk($sformatf("vec%0d error", i), {31'd0, er8}, {31'd0, vecs[i].er});
            chk($sformatf("vec%0d err_count", i), {16'd0, ec8}, {16'd0, vecs[i].ec});
            chk($sformatf("vec%0d word_count", i), {16'd0, wc8}, {16'd0, vecs[i].wc});
        end

        // Resync in VERIFY: AA restarts the match count, so 3 more matches do not lock
        pulse_reset();
        step8(1'b1, 8'hFF, 1'b0);
        step8(1'b1, 8'h7F, 1'b0);
        step8(1'b1, 8'hAA, 1'b0);
        chk("resync state", {30'd0, st8}, 32'd1);
        step8(1'b1, 8'hD5, 1'b0);
        step8(1'b1, 8'hEA, 1'b0);
        step8(1'b1, 8'h75, 1'b0);
        chk("resync not yet locked", {31'd0, lk8}, 32'd0);
        step8(1'b1, 8'h3A, 1'b0);
        chk("resync locks", {31'd0, lk8}, 32'd1);
        chk("resync lock state", {30'd0, st8}, 32'd2);

        // N=4 with idle cycles between words
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            v4 = 1'b1; w4 = seq4[i];
            @(posedge clk);
            #1;
            chk($sformatf("n4 word%0d state", i), {30'd0, st4}, {30'd0, exp4[i]});
            v4 = 1'b0; w4 = 4'h5;
            @(posedge clk);
            #1;
            chk($sformatf("n4 gap%0d state", i), {30'd0, st4}, {30'd0, exp4[i]});
        end
        chk("n4 locked", {31'd0, lk4}, 32'd1);
        v4 = 1'b1; w4 = 4'h4;
        @(posedge clk);
        #1 v4 = 1'b0;
        chk("n4 word_count", {16'd0, wc4}, 32'd1);
        chk("n4 error", {31'd0, er4}, 32'd0);

        // Narrow counters: 21 errors over 7 relocks saturate at F
        pulse_reset();
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < 5; k++) steps(lock_seq[k], 1'b0);
            for (int k = 0; k < 3; k++) steps(8'h55, 1'b0);
        end
        chk("sat err_count", {28'd0, ecs}, 32'hF);
        chk("sat word_count", {28'd0, wcs}, 32'hF);
        chk("sat state hunt", {30'd0, sts}, 32'd0);
        for (int k = 0; k < 5; k++) steps(lock_seq[k], 1'b0);
        steps(8'h55, 1'b1);
        chk("clear vs error pulse", {31'd0, ers}, 32'd1);
        chk("clear wins err_count", {28'd0, ecs}, 32'd0);
        chk("clear keeps lock", {31'd0, lks}, 32'd1);
        steps(8'h55, 1'b0);
        chk("post-clear err_count", {28'd0, ecs}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async reset locked", {31'd0, lks}, 32'd0);
        chk("async reset error", {31'd0, ers}, 32'd0);
        chk("async reset err_count", {28'd0, ecs}, 32'd0);
        chk("async reset word_count", {28'd0, wcs}, 32'd0);
        chk("async reset state", {30'd0, sts}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        steps(8'hFF, 1'b0);
        chk("rehunt after reset", {30'd0, sts}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
